im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_pkg.sv | 22 ++
 rtl/im_loader_packer.sv | 44 ++++
 rtl/im_loader.sv | 170 +++++++++++++++++
 tb/tb_im_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package im_loader_pkg;
    localparam int IM_DEPTH       = 1024;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = 2;
    localparam int CNT_W          = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [BYTE_W-1:0] sum8(input logic [BYTE_W-1:0] acc,
                                               input logic [BYTE_W-1:0] b);
        return acc + b;
    endfunction
endpackage

// File: rtl/im_loader_packer.sv
// Big-endian byte-to-word shift assembler with a per-word byte counter.
module im_loader_packer
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Shift in accepted bytes; first byte ends up in the top lane.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = {BCNT_W{1'b0}};
            word_d = {WORD_W{1'b0}};
        end else if (accept_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Counter and assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {BCNT_W{1'b0}};
            word_q <= {WORD_W{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = accept_i & ~clear_i & (cnt_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/im_loader.sv
// Streams bytes into instruction memory while holding the core in reset.
// Optional trailing checksum byte enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [CNT_W-1:0]  load_words,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] IM_address,
    output logic [WORD_W-1:0] IM_in,
    output logic              IM_write,
    output logic              IM_enable,
    output logic              IM_read,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << ADDR_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  clamp_s;
    logic              clear_s;
    logic              accept_s;
    logic              word_done_s;
    logic              last_word_s;
    logic [WORD_W-1:0] word_s;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              chk_accept_s;
`endif

    assign clamp_s     = (load_words > DEPTH_C) ? DEPTH_C : load_words;
    assign accept_s    = rx_valid & (state_q == ST_COLLECT);
    assign last_word_s = ((CNT_W'(addr_q) + 11'd1) == words_q);

    im_loader_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_s),
        .accept_i    (accept_s),
        .byte_i      (rx_data),
        .word_o      (word_s),
        .word_done_o (word_done_s)
    );

`ifdef IM_LOADER_CHECKSUM_EN
    assign chk_accept_s = rx_valid & (state_q == ST_CHECK);
`endif

    // Next-state, address and count control.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        clear_s = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    words_d = clamp_s;
                    addr_d  = {ADDR_W{1'b0}};
                    clear_s = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                    sum_d   = {BYTE_W{1'b0}};
                    err_d   = 1'b0;
`endif
                    state_d = (clamp_s == 11'd0) ? ST_DONE : ST_COLLECT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COLLECT: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (accept_s) begin
                    sum_d = sum8(sum_q, rx_data);
                end else begin
                    sum_d = sum_q;
                end
`endif
                if (word_done_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                // Address only advances when another word follows, so it never wraps.
                if (last_word_s) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_COLLECT;
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (chk_accept_s) begin
                    err_d   = (rx_data != sum_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address and word-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            words_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    // Running byte sum and latched checksum verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= {BYTE_W{1'b0}};
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign error    = err_q;
    assign rx_ready = (state_q == ST_COLLECT) | (state_q == ST_CHECK);
    assign busy     = (state_q == ST_COLLECT) | (state_q == ST_WRITE) | (state_q == ST_CHECK);
`else
    assign error    = 1'b0;
    assign rx_ready = (state_q == ST_COLLECT);
    assign busy     = (state_q == ST_COLLECT) | (state_q == ST_WRITE);
`endif

    assign IM_address = addr_q;
    assign IM_in      = word_s;
    assign IM_write   = (state_q == ST_WRITE);
    assign IM_enable  = (state_q == ST_WRITE);
    assign IM_read    = 1'b0;
    assign done       = (state_q == ST_DONE);
    assign cpu_rst    = (state_q != ST_DONE);
endmodule

// File: tb/tb_im_loader.sv
// Directed, table-driven bench for im_loader with a write-capturing memory model.
module tb_im_loader;
    logic        clk;
    logic        rst;
    logic        load_start;
    logic [10:0] load_words;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [9:0]  IM_address;
    logic [31:0] IM_in;
    logic        IM_write, IM_enable, IM_read;
    logic        cpu_rst, busy, done, error;

    im_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_words(load_words),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .IM_address(IM_address), .IM_in(IM_in), .IM_write(IM_write),
        .IM_enable(IM_enable), .IM_read(IM_read), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          wr_addr0 = 0;
    int          wr_addr1 = 0;
    int          busy_cyc = 0;
    int          strobe_err = 0;
    int          last_addr = -1;

    // Memory model: capture every write mid-cycle.
    always @(negedge clk) begin
        if (IM_write) begin
            mem[IM_address] = IM_in;
            wr_cnt = wr_cnt + 1;
            last_addr = int'(IM_address);
            if (IM_address == 10'd0) wr_addr0 = wr_addr0 + 1;
            if (IM_address == 10'd1) wr_addr1 = wr_addr1 + 1;
        end
        if (busy) busy_cyc = busy_cyc + 1;
        if (IM_read || (IM_write != IM_enable)) strobe_err = strobe_err + 1;
    end

    logic [7:0] bbuf [0:8191];
    int         first_wr_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [10:0] w);
        @(negedge clk);
        load_start = 1'b1;
        load_words = w;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Present bbuf[0..n-1]; caller is at a negedge. Ends with rx_valid low.
    task automatic feed(input int n, input bit toggle, input int budget, input string nm);
        int i = 0;
        int c = 0;
        while (i < n && c < budget) begin
            if (IM_write && first_wr_i < 0) first_wr_i = i;
            rx_valid = toggle ? (c % 2 == 0) : 1'b1;
            rx_data  = bbuf[i];
            if (rx_valid && rx_ready) i = i + 1;
            c = c + 1;
            @(negedge clk);
        end
        if (IM_write && first_wr_i < 0) first_wr_i = i;
        rx_valid = 1'b0;
        chk({nm, "_bytes"}, 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c = c + 1;
        end
        chk({nm, "_done"}, {63'd0, done}, 64'd1);
    endtask

    function automatic logic [7:0] sum_bytes(input int n);
        logic [7:0] s = 8'd0;
        for (int k = 0; k < n; k++) s = s + bbuf[k];
        return s;
    endfunction

    typedef struct packed {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_word;
        logic [7:0]  exp_sum;
    } vec_t;

    vec_t vecs [5];
    int   extra;
    int   base_wr, base_a0, base_a1, base_busy;

    initial begin
        vecs[0] = '{b0:8'h01, b1:8'h23, b2:8'h45, b3:8'h67, exp_word:32'h01234567, exp_sum:8'hD0};
        vecs[1] = '{b0:8'hDE, b1:8'hAD, b2:8'hBE, b3:8'hEF, exp_word:32'hDEADBEEF, exp_sum:8'h38};
        vecs[2] = '{b0:8'h00, b1:8'h00, b2:8'h00, b3:8'h00, exp_word:32'h00000000, exp_sum:8'h00};
        vecs[3] = '{b0:8'hFF, b1:8'hFF, b2:8'hFF, b3:8'hFF, exp_word:32'hFFFFFFFF, exp_sum:8'hFC};
        vecs[4] = '{b0:8'h80, b1:8'h01, b2:8'h7F, b3:8'h10, exp_word:32'h80017F10, exp_sum:8'h10};
`ifdef IM_LOADER_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif
        rst = 1'b1; load_start = 1'b0; load_words = 11'd0; rx_valid = 1'b0; rx_data = 8'd0;
        first_wr_i = -1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({IM_address, IM_in, IM_write, IM_enable, IM_read, rx_ready, busy, done, error, cpu_rst}),
            64'd1);
        rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ignores_rx", {62'd0, rx_ready, busy}, 64'd0);
        rx_valid = 1'b0;

        // Two-word continuous load.
        bbuf[0] = 8'h01; bbuf[1] = 8'h23; bbuf[2] = 8'h45; bbuf[3] = 8'h67;
        bbuf[4] = 8'h89; bbuf[5] = 8'hAB; bbuf[6] = 8'hCD; bbuf[7] = 8'hEF;
        bbuf[8] = 8'hC0;
        base_wr = wr_cnt; base_busy = busy_cyc;
        start(11'd2);
        chk("two_busy_cpu_rst", {62'd0, busy, cpu_rst}, 64'd3);
        feed(8 + extra, 1'b0, 100, "two");
        wait_done(20, "two");
        chk("two_im0", 64'(mem[0]), 64'h01234567);
        chk("two_im1", 64'(mem[1]), 64'h89ABCDEF);
        chk("two_writes", 64'(wr_cnt - base_wr), 64'd2);
        chk("two_cycles", 64'(busy_cyc - base_busy), 64'(10 + extra));
        chk("two_done_status", {61'd0, cpu_rst, busy, error}, 64'd0);

        // Single-word vectors.
        for (int v = 0; v < 5; v++) begin
            bbuf[0] = vecs[v].b0; bbuf[1] = vecs[v].b1;
            bbuf[2] = vecs[v].b2; bbuf[3] = vecs[v].b3;
            bbuf[4] = vecs[v].exp_sum;
            base_wr = wr_cnt;
            start(11'd1);
            feed(4 + extra, 1'b0, 50, "vec");
            wait_done(20, "vec");
            chk("vec_word", 64'(mem[0]), 64'(vecs[v].exp_word));
            chk("vec_writes", 64'(wr_cnt - base_wr), 64'd1);
            chk("vec_addr_err", {53'd0, IM_address, error}, 64'd0);
        end

        // One word with rx_valid toggling.
        bbuf[0] = 8'hA5; bbuf[1] = 8'h5A; bbuf[2] = 8'h3C; bbuf[3] = 8'hC3;
        bbuf[4] = 8'hA5 + 8'h5A + 8'h3C + 8'hC3;
        base_wr = wr_cnt; first_wr_i = -1;
        start(11'd1);
        feed(4 + extra, 1'b1, 60, "tog");
        wait_done(20, "tog");
        chk("tog_word", 64'(mem[0]), 64'hA55A3CC3);
        chk("tog_writes", 64'(wr_cnt - base_wr), 64'd1);
        chk("tog_first_write_after", 64'(first_wr_i), 64'd4);

        // Zero-length load.
        base_wr = wr_cnt;
        start(11'd0);
        chk("zero_status", {61'd0, done, cpu_rst, busy}, 64'd4);
        repeat (3) @(negedge clk);
        chk("zero_writes", 64'(wr_cnt - base_wr), 64'd0);

        // Oversized load is clamped to the memory depth.
        for (int k = 0; k < 4096; k++) bbuf[k] = 8'(k * 7 + (k >> 8));
        bbuf[4096] = sum_bytes(4096);
        base_wr = wr_cnt; base_a0 = wr_addr0;
        start(11'd1500);
        feed(4096 + extra, 1'b0, 6000, "big");
        wait_done(20, "big");
        chk("big_writes", 64'(wr_cnt - base_wr), 64'd1024);
        chk("big_last_addr", 64'(last_addr), 64'd1023);
        chk("big_addr0_once", 64'(wr_addr0 - base_a0), 64'd1);
        chk("big_last_word", 64'(mem[1023]), 64'({bbuf[4092], bbuf[4093], bbuf[4094], bbuf[4095]}));
        chk("big_first_word", 64'(mem[0]), 64'({bbuf[0], bbuf[1], bbuf[2], bbuf[3]}));
        chk("big_final_address", 64'(IM_address), 64'd1023);
        start(11'd1);
        chk("busy_after_restart", {62'd0, busy, done}, 64'd2);
        start(11'd2);
        chk("start_ignored_busy", {62'd0, busy, done}, 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a three-word load.
        for (int k = 0; k < 12; k++) bbuf[k] = 8'(8'h10 + k);
        base_wr = wr_cnt; base_a1 = wr_addr1;
        start(11'd3);
        feed(6, 1'b0, 40, "rst");
        rst = 1'b1;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs",
            64'({IM_address, IM_in, IM_write, IM_enable, IM_read, rx_ready, busy, done, error, cpu_rst}),
            64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        rx_valid = 1'b0;
        chk("rst_writes", 64'(wr_cnt - base_wr), 64'd1);
        chk("rst_im1_unwritten", 64'(wr_addr1 - base_a1), 64'd0);
        chk("rst_idle", {61'd0, busy, done, cpu_rst}, 64'd1);

`ifdef IM_LOADER_CHECKSUM_EN
        bbuf[0] = 8'h01; bbuf[1] = 8'h02; bbuf[2] = 8'h03; bbuf[3] = 8'h04; bbuf[4] = 8'h0A;
        start(11'd1);
        feed(5, 1'b0, 40, "ck_good");
        wait_done(10, "ck_good");
        chk("ck_good_err", {63'd0, error}, 64'd0);
        bbuf[4] = 8'h0B;
        start(11'd1);
        feed(5, 1'b0, 40, "ck_bad");
        wait_done(10, "ck_bad");
        chk("ck_bad_err", {62'd0, error, done}, 64'd3);
        start(11'd0);
        chk("ck_restart_clears", {62'd0, error, done}, 64'd1);
`endif

        chk("strobe_rules", 64'(strobe_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
